weighted_rr_arbiter: RTL and testbench
======================================

Name: weighted_rr_arbiter

Overview:
Parametrised weighted round-robin arbiter. It generalises the fixed 8-way single-cycle round-robin arbiter to N requesters. Each requester gets a per-requester burst weight, and an optional lock extends the current grant. The output is a registered one-hot grant plus an encoded owner index, and it feeds the shared-resource muxes in the interconnect.

Parameters:
N, 8, number of requesters (N >= 2)
WW, 4, width of each per-requester weight field
IW, $clog2(N), width of grant_id (derived; do not override)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset; synchronous, active-high
req  input  N  request vector; bit i = requester i
weights  input  N*WW  weight of requester i in bits [i*WW +: WW]
lock  input  1  extend current owner's grant past its weight while owner's req stays high
grants  output  N  registered one-hot grant, all-zero when idle
grant_valid  output  1  registered; high when grants is non-zero
grant_id  output  IW  registered index of the current owner; holds its last value when idle

Behaviour:
- Reset (rst sampled high at an edge):
  - grants=0, grant_valid=0, grant_id=0.
  - Round-robin pointer ptr=0, credit counter=0, FSM=IDLE.
  - Reset mid-grant drops the grant on that same edge; no partial state survives.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE with outputs at 0.
  - Otherwise pick the winner: the first set req bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On that edge: grants=onehot(winner), grant_id=winner, grant_valid=1.
  - Load credit=weights[winner], with a weight of 0 treated as 1. Go to GRANT.
  - Latency: req sampled at edge e, grants visible after edge e.
- GRANT, with owner o, evaluated each edge:
  - Hold: req[o]=1 and (credit>1 or lock=1). Grant is unchanged. credit decrements when credit>1 and lock=0; when lock=1 it does not decrement.
  - Release: req[o]=0, or (credit==1 and lock=0). Set ptr=(o+1) mod N, wrapping at N-1→0. In the same edge, arbitrate the current req with search start (o+1) mod N.
    - If a winner exists, grant it on this edge with no bubble cycle, reload credit, and stay in GRANT.
    - If no winner exists, set grants=0, grant_valid=0, and go to IDLE.
  - The released owner is eligible again in the same search, but with lowest priority. A sole persistent requester therefore keeps a continuous grant, re-arming credit each weight period.
- A weight W with req held high gives exactly W consecutive grant cycles (lock low).
- Early drop: when req[o] falls, grants moves on the first edge that samples req[o]=0.
- Weights are sampled only when a grant is issued. Changes mid-burst take effect at the next grant to that requester.
- lock is ignored in IDLE. lock high with req[o]=0 still releases.
- Credit counter width is WW, so the maximum burst is 2^WW-1 (lock aside).
- grants is always one-hot or zero; grant_valid == |grants at all times.

Test Plan:
- N=8, all weights=1, req=8'b11111111 held 9 cycles after reset → grants 0x01,0x02,0x04,…,0x80,0x01; grant_id 0..7,0; no idle cycle.
- All weights=1, req=8'b10011011 held → grants 0x01,0x02,0x08,0x10,0x80,0x01 (skips idle bits, wraps).
- weights[0]=3, weights[1]=1, req=8'b00000011 held → 0x01 ×3, 0x02 ×1, 0x01 ×3, repeating; weights[0]=0 instead → 0x01 ×1 alternation.
- weights[2]=4, req=8'b00000100 for 2 edges then 8'b00001000 → 0x04 for 2 cycles, then 0x08 on the first edge sampling req[2]=0; ptr advanced so req=8'b00001100 afterwards yields 0x08 before 0x04.
- weights[1]=2, lock=1, req=8'b00000011 held 6 edges → 0x02 never released while lock=1; drop lock → 0x02 released after 1 more cycle, then 0x01.
- All weights=1, req=0xFF, rst=1 while grants=0x08 → next edge grants=0, grant_valid=0, grant_id=0; after rst low, the first grant is 0x01 (ptr reset).

Source files
------------

// File: rtl/weighted_rr_arbiter.sv
// -----------------------------------------------------------------------------
// weighted_rr_arbiter
//
// Weighted round-robin arbiter for N requesters. A winner keeps the grant for
// up to its weight in consecutive cycles (weight 0 counts as 1). While lock is
// high, the current owner keeps the grant for as long as it keeps requesting.
// On release, the next owner is chosen on the same edge, so there is no bubble
// cycle between grants. The search starts just after the released owner.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req         [N-1:0]    request vector, bit i = requester i
//   weights     [N*WW-1:0] burst weight of requester i in [i*WW +: WW]
//   lock        extend the current owner's grant while its req stays high
//   grants      [N-1:0]    registered one-hot grant, zero when idle
//   grant_valid registered, equals |grants
//   grant_id    [IW-1:0]   registered owner index, holds last value when idle
// -----------------------------------------------------------------------------
module weighted_rr_arbiter #(
    parameter int N  = 8,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weights,
    input  logic            lock,
    output logic [N-1:0]    grants,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_next;
    logic [WW-1:0]   r_credit;
    logic [WW-1:0]   w_credit_next;
    logic [N-1:0]    r_grants;
    logic [N-1:0]    w_grants_next;
    logic            r_valid;
    logic            w_valid_next;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   w_grant_id_next;

    // Effective weights: a programmed weight of 0 still buys one cycle.
    logic [WW-1:0]   w_weight_eff [N];

    // Rotated request view: slot k holds req[(start + k) mod N].
    logic [IW-1:0]   w_rot_idx [N];
    logic [N-1:0]    w_rot_req;

    logic [IW-1:0]   w_owner_succ;
    logic [IW-1:0]   w_search_start;
    logic            w_owner_req;
    logic            w_hold;
    logic            w_found;
    logic [IW-1:0]   w_winner;

    genvar gi;

    generate
        for (gi = 0; gi < N; gi++) begin : g_weight
            logic [WW-1:0] w_field;
            assign w_field          = weights[gi*WW +: WW];
            assign w_weight_eff[gi] = (w_field == '0) ? WW'(1) : w_field;
        end
    endgenerate

    // Successor of the current owner, wrapping N-1 -> 0 for any N.
    assign w_owner_succ = (r_grant_id == IW'(N - 1)) ? '0 : r_grant_id + IW'(1);

    // In GRANT the search only matters on release, and then it starts just
    // after the owner, which is also the pointer value being written.
    assign w_search_start = (r_state == S_GRANT) ? w_owner_succ : r_ptr;

    generate
        for (gi = 0; gi < N; gi++) begin : g_rotate
            logic [IW:0] w_sum;
            assign w_sum          = {1'b0, w_search_start} + (IW+1)'(gi);
            assign w_rot_idx[gi]  = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N))
                                                          : w_sum[IW-1:0];
            assign w_rot_req[gi]  = req[w_rot_idx[gi]];
        end
    endgenerate

    // Lowest rotated slot wins. The released owner sits in the last slot,
    // which gives it the lowest priority in its own release search.
    always_comb begin
        w_found  = |w_rot_req;
        w_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot_req[k]) begin
                w_winner = w_rot_idx[k];
            end
        end
    end

    assign w_owner_req = req[r_grant_id];
    assign w_hold      = w_owner_req && ((r_credit > WW'(1)) || lock);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_credit   <= '0;
            r_grants   <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_credit   <= w_credit_next;
            r_grants   <= w_grants_next;
            r_valid    <= w_valid_next;
            r_grant_id <= w_grant_id_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_hold && !w_found) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output / datapath logic (feeds the registered outputs)
    always_comb begin
        w_ptr_next      = r_ptr;
        w_credit_next   = r_credit;
        w_grants_next   = r_grants;
        w_valid_next    = r_valid;
        w_grant_id_next = r_grant_id;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grants_next   = {{(N-1){1'b0}}, 1'b1} << w_winner;
                    w_valid_next    = 1'b1;
                    w_grant_id_next = w_winner;
                    w_credit_next   = w_weight_eff[w_winner];
                end else begin
                    w_grants_next = '0;
                    w_valid_next  = 1'b0;
                end
            end
            S_GRANT: begin
                if (w_hold) begin
                    // Lock freezes the credit; otherwise credit > 1 here.
                    if (!lock) begin
                        w_credit_next = r_credit - WW'(1);
                    end
                end else begin
                    w_ptr_next = w_owner_succ;
                    if (w_found) begin
                        w_grants_next   = {{(N-1){1'b0}}, 1'b1} << w_winner;
                        w_valid_next    = 1'b1;
                        w_grant_id_next = w_winner;
                        w_credit_next   = w_weight_eff[w_winner];
                    end else begin
                        w_grants_next = '0;
                        w_valid_next  = 1'b0;
                        w_credit_next = '0;
                    end
                end
            end
            default: begin
                w_grants_next = '0;
                w_valid_next  = 1'b0;
            end
        endcase
    end

    assign grants      = r_grants;
    assign grant_valid = r_valid;
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_weighted_rr_arbiter
//
// Directed bench for weighted_rr_arbiter (N=8, WW=4). A behavioural model
// tracks owner / burst budget / pointer as plain integers and is compared
// against the DUT outputs on every falling edge; hand-written expected grant
// sequences pin both the model and the DUT at key points.
// -----------------------------------------------------------------------------
module tb_weighted_rr_arbiter;

    localparam int N  = 8;
    localparam int WW = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*WW-1:0]   weights;
    logic              lock;
    logic [N-1:0]      grants;
    logic              grant_valid;
    logic [2:0]        grant_id;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_owner   = -1;   // -1 means idle
    int          m_ptr     = 0;
    int          m_used    = 0;    // non-locked cycles already spent in burst
    int          m_budget  = 1;
    logic [2:0]  m_id      = 3'd0;
    bit          m_started = 1'b0;
    int          cycle     = 0;

    weighted_rr_arbiter #(.N(N), .WW(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weights     (weights),
        .lock        (lock),
        .grants      (grants),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (((r >> idx) & 8'd1) != 8'd0) return idx;
        end
        return -1;
    endfunction

    function automatic int budget_of(input logic [N*WW-1:0] wv, input int who);
        int b;
        b = int'((wv >> (who * WW)) & 32'hF);
        return (b == 0) ? 1 : b;
    endfunction

    task automatic grant_to(input int w);
        if (w < 0) begin
            m_owner = -1;
        end else begin
            m_owner  = w;
            m_id     = 3'(w);
            m_used   = 0;
            m_budget = budget_of(weights, w);
        end
    endtask

    // Advance the model by one rising edge using the inputs now being sampled.
    task automatic model_step();
        m_started = 1'b1;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_used  = 0;
            m_id    = 3'd0;
        end else if (m_owner < 0) begin
            grant_to(pick(req, m_ptr));
        end else begin
            bit own_req;
            own_req = (((req >> m_owner) & 8'd1) != 8'd0);
            if (own_req && (lock || (m_used + 1 < m_budget))) begin
                if (!lock) m_used++;
            end else begin
                m_ptr = (m_owner + 1) % N;
                grant_to(pick(req, m_ptr));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (m_started) begin
            logic [N-1:0] eg;
            eg = (m_owner < 0) ? 8'h00 : (8'(1) << m_owner);
            vectors++;
            if (grants !== eg || grant_valid !== (m_owner >= 0) || grant_id !== m_id) begin
                miscompares++;
                $display("FAIL model cycle %0d: grants=%h valid=%b id=%0d, expected grants=%h valid=%b id=%0d",
                         cycle, grants, grant_valid, grant_id, eg, (m_owner >= 0), m_id);
            end
            cycle++;
        end
    end

    // Hand-computed literal expectation
    task automatic lit(input string nm, input logic [N-1:0] eg, input logic [2:0] eid);
        vectors++;
        if (grants !== eg || grant_valid !== (eg != 8'h00) || grant_id !== eid) begin
            miscompares++;
            $display("FAIL %s: grants=%h valid=%b id=%0d, expected grants=%h valid=%b id=%0d",
                     nm, grants, grant_valid, grant_id, eg, (eg != 8'h00), eid);
        end else begin
            $display("ok   %s: grants=%h id=%0d", nm, grants, grant_id);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        lock = 1'b0;
        tick();
        tick();
        lit("reset", 8'h00, 3'd0);
        rst = 1'b0;
    endtask

    logic [7:0] t_rr9b  [6] = '{8'h01, 8'h02, 8'h08, 8'h10, 8'h80, 8'h01};
    logic [2:0] t_id9b  [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd7, 3'd0};
    logic [7:0] t_w3    [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
    logic [31:0] t_wmix [4] = '{32'h1111_1111, 32'h2031_0F02, 32'h0304_2150, 32'h5112_3004};

    initial begin
        rst     = 1'b1;
        req     = '0;
        lock    = 1'b0;
        weights = 32'h1111_1111;

        // All weights 1, all requesting: plain round robin with wrap
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            lit("rr_all", 8'(1) << (i % 8), 3'(i % 8));
        end

        // Sparse requests skip idle bits and wrap
        do_reset();
        req = 8'b1001_1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            lit("rr_sparse", t_rr9b[i], t_id9b[i]);
        end

        // weight 3 vs weight 1
        weights = 32'h1111_1113;
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 8; i++) begin
            tick();
            lit("weight3", t_w3[i], (t_w3[i] == 8'h01) ? 3'd0 : 3'd1);
        end

        // weight 0 behaves as 1
        weights = 32'h1111_1110;
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("weight0", (i % 2 == 0) ? 8'h01 : 8'h02, 3'(i % 2));
        end

        // Early drop and pointer advance
        weights = 32'h1111_1411;
        do_reset();
        req = 8'h04;
        tick(); lit("drop_a", 8'h04, 3'd2);
        tick(); lit("drop_b", 8'h04, 3'd2);
        req = 8'h08;
        tick(); lit("drop_c", 8'h08, 3'd3);
        req = 8'h0C;
        tick(); lit("drop_d", 8'h04, 3'd2);

        // Lock extends the grant past its weight
        weights = 32'h1111_1121;
        do_reset();
        req = 8'h02;
        tick(); lit("lock_start", 8'h02, 3'd1);
        req  = 8'h03;
        lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); lit("lock_hold", 8'h02, 3'd1);
        end
        lock = 1'b0;
        tick(); lit("lock_tail", 8'h02, 3'd1);
        tick(); lit("lock_rel", 8'h01, 3'd0);

        // Lock with owner request low still releases
        weights = 32'h1111_1111;
        do_reset();
        req  = 8'h01;
        lock = 1'b1;
        tick(); lit("lockdrop_a", 8'h01, 3'd0);
        tick(); lit("lockdrop_b", 8'h01, 3'd0);
        req = 8'h02;
        tick(); lit("lockdrop_c", 8'h02, 3'd1);
        tick(); lit("lockdrop_d", 8'h02, 3'd1);
        lock = 1'b0;

        // Maximum burst: weight 15
        weights = 32'h1111_111F;
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 15; i++) tick();
        lit("wmax_last", 8'h01, 3'd0);
        tick(); lit("wmax_next", 8'h02, 3'd1);

        // Reset mid-grant
        weights = 32'h1111_1111;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 4; i++) tick();
        lit("pre_rst", 8'h08, 3'd3);
        rst = 1'b1;
        tick(); lit("mid_rst", 8'h00, 3'd0);
        rst = 1'b0;
        tick(); lit("post_rst", 8'h01, 3'd0);

        // Mixed directed sweep, checked by the model only (weights change mid-burst)
        for (int i = 0; i < 300; i++) begin
            if (i % 5 == 0) weights = t_wmix[(i / 5) % 4];
            req  = 8'((i * 37 + (i >> 3) * 11) & 8'hFF) & ((i % 9 == 0) ? 8'h00 : 8'hFF);
            lock = (i % 7 == 3) || (i % 7 == 4);
            rst  = (i == 150);
            tick();
        end
        rst = 1'b0;
        req = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
